// File: rtl/adder32_pkg.sv
// Shared widths and state encoding for the adder32 sequencer and its helpers.
package adder32_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 8;
  localparam int ACC_W_DEF  = DATA_W_DEF + CNT_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/adder32_golden.sv
// Behavioural reference adder (DATA_W + DATA_W -> DATA_W+1) used to cross-check
// an external, possibly locked, adder instance.
module adder32_golden
  import adder32_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] add1,
  input  logic [DATA_W-1:0] add2,
  output logic [DATA_W:0]   sum
);

  assign sum = {1'b0, add1} + {1'b0, add2};

endmodule

// File: rtl/adder32_accum_seq.sv
// Burst accumulator driving an external 32-bit adder; every adder result is
// compared with an internal golden sum and disagreements set a sticky flag.
module adder32_accum_seq
  import adder32_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [CNT_W-1:0]        len_i,
  input  logic                    op_valid_i,
  input  logic [DATA_W-1:0]       op_data_i,
  output logic                    op_ready_o,
  output logic [DATA_W-1:0]       add1_o,
  output logic [DATA_W-1:0]       add2_o,
  input  logic [DATA_W:0]         sum_i,
  output logic                    res_valid_o,
  output logic [DATA_W+CNT_W-1:0] res_data_o,
  input  logic                    res_ready_i,
  output logic                    mismatch_o,
  output logic                    busy_o
);

  localparam int ACC_W = DATA_W + CNT_W;

  state_e             state_r;
  logic [ACC_W-1:0]   acc_r;
  logic [ACC_W-1:0]   res_data_r;
  logic [CNT_W-1:0]   rem_r;
  logic               mismatch_r;
  logic               ready_r;
  logic               res_valid_r;
  logic               busy_r;

  logic               beat_s;
  logic [DATA_W-1:0]  add2_s;
  logic [DATA_W:0]    golden_s;
  logic [ACC_W-1:0]   acc_next_s;

  assign beat_s = op_valid_i & ready_r;

  // Operand path to the adder is only opened while accumulating.
  always_comb begin
    add2_s = '0;
    if (ready_r) begin
      add2_s = op_data_i;
    end else begin
      add2_s = '0;
    end
  end

  // Low half takes the adder sum directly; its carry-out bumps the upper counter bits.
  assign acc_next_s = {acc_r[ACC_W-1:DATA_W] + CNT_W'(sum_i[DATA_W]), sum_i[DATA_W-1:0]};

  adder32_golden #(
    .DATA_W (DATA_W)
  ) u_golden (
    .add1 (acc_r[DATA_W-1:0]),
    .add2 (add2_s),
    .sum  (golden_s)
  );

  // Sequencer FSM, remaining-count, accumulator and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      acc_r       <= '0;
      res_data_r  <= '0;
      rem_r       <= '0;
      mismatch_r  <= 1'b0;
      ready_r     <= 1'b0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            acc_r      <= '0;
            mismatch_r <= 1'b0;
            busy_r     <= 1'b1;
            if (len_i != '0) begin
              rem_r   <= len_i;
              ready_r <= 1'b1;
              state_r <= ST_ACCUM;
            end else begin
              res_data_r  <= '0;
              res_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end
          end
        end
        ST_ACCUM: begin
          if (beat_s) begin
            acc_r      <= acc_next_s;
            rem_r      <= rem_r - CNT_W'(1);
            mismatch_r <= mismatch_r | (sum_i != golden_s);
            if (rem_r == CNT_W'(1)) begin
              res_data_r  <= acc_next_s;
              res_valid_r <= 1'b1;
              ready_r     <= 1'b0;
              state_r     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (res_ready_i) begin
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          ready_r     <= 1'b0;
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign op_ready_o  = ready_r;
  assign add1_o      = acc_r[DATA_W-1:0];
  assign add2_o      = add2_s;
  assign res_valid_o = res_valid_r;
  assign res_data_o  = res_data_r;
  assign mismatch_o  = mismatch_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_adder32_accum_seq.sv
// Directed and randomized bursts against an arithmetic reference of the
// accumulated sum, with an external adder model that can inject a fault.
module tb_adder32_accum_seq;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [7:0]  len_i;
  logic        op_valid_i;
  logic [31:0] op_data_i;
  logic        op_ready_o;
  logic [31:0] add1_o;
  logic [31:0] add2_o;
  logic [32:0] sum_i;
  logic        res_valid_o;
  logic [39:0] res_data_o;
  logic        res_ready_i;
  logic        mismatch_o;
  logic        busy_o;

  logic        fault_flip;
  int          checks;
  int          errors;
  longint      ref_acc;
  logic        ref_mm;
  logic [31:0] op_q[$];

  adder32_accum_seq dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .len_i       (len_i),
    .op_valid_i  (op_valid_i),
    .op_data_i   (op_data_i),
    .op_ready_o  (op_ready_o),
    .add1_o      (add1_o),
    .add2_o      (add2_o),
    .sum_i       (sum_i),
    .res_valid_o (res_valid_o),
    .res_data_o  (res_data_o),
    .res_ready_i (res_ready_i),
    .mismatch_o  (mismatch_o),
    .busy_o      (busy_o)
  );

  // External adder; fault_flip models a wrongly keyed locked adder.
  assign sum_i = ({1'b0, add1_o} + {1'b0, add2_o}) ^ {32'd0, fault_flip};

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_burst(input string tag, input int len, input int fault_beat,
                           input bit gappy, input bit poke_start);
    int          beats;
    int          cyc;
    logic [31:0] a;
    logic [31:0] op;
    longint      g;
    longint      s;
    ref_acc = 0;
    ref_mm  = 1'b0;
    start_i = 1'b1;
    len_i   = len[7:0];
    step();
    start_i = 1'b0;
    len_i   = 8'd0;
    chk({tag, "_busy"}, {63'd0, busy_o}, 64'd1);
    chk({tag, "_mm_clr"}, {63'd0, mismatch_o}, 64'd0);
    beats = 0;
    cyc   = 0;
    while (beats < len && cyc < 4 * len + 16) begin
      start_i = poke_start && (cyc == 1);
      len_i   = start_i ? 8'd50 : 8'd0;
      if (!gappy || $urandom_range(0, 1) == 1) begin
        op         = op_q[beats];
        op_valid_i = 1'b1;
        op_data_i  = op;
        fault_flip = (beats + 1 == fault_beat);
        #1;
        chk({tag, "_ready"}, {63'd0, op_ready_o}, 64'd1);
        chk({tag, "_add1"}, {32'd0, add1_o}, {32'd0, ref_acc[31:0]});
        chk({tag, "_add2"}, {32'd0, add2_o}, {32'd0, op});
        a = ref_acc[31:0];
        g = longint'(a) + longint'(op);
        s = fault_flip ? (g ^ 64'd1) : g;
        if (fault_flip) ref_mm = 1'b1;
        ref_acc = ref_acc - longint'(a) + s;
        step();
        beats++;
        chk({tag, "_mm"}, {63'd0, mismatch_o}, {63'd0, ref_mm});
      end else begin
        op_valid_i = 1'b0;
        op_data_i  = $urandom;
        fault_flip = 1'b0;
        step();
      end
      cyc++;
    end
    start_i    = 1'b0;
    len_i      = 8'd0;
    op_valid_i = 1'b0;
    fault_flip = 1'b0;
    op_data_i  = $urandom;
    #1;
    chk({tag, "_beats"}, 64'(beats), 64'(len));
    chk({tag, "_add2_idle"}, {32'd0, add2_o}, 64'd0);
    chk({tag, "_ready_done"}, {63'd0, op_ready_o}, 64'd0);
    chk({tag, "_valid"}, {63'd0, res_valid_o}, 64'd1);
    chk({tag, "_res"}, {24'd0, res_data_o}, {24'd0, ref_acc[39:0]});
    chk({tag, "_mm_done"}, {63'd0, mismatch_o}, {63'd0, ref_mm});
  endtask

  task automatic accept(input string tag, input int hold);
    res_ready_i = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_valid"}, {63'd0, res_valid_o}, 64'd1);
      chk({tag, "_hold_res"}, {24'd0, res_data_o}, {24'd0, ref_acc[39:0]});
      chk({tag, "_hold_mm"}, {63'd0, mismatch_o}, {63'd0, ref_mm});
    end
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    chk({tag, "_idle_valid"}, {63'd0, res_valid_o}, 64'd0);
    chk({tag, "_idle_busy"}, {63'd0, busy_o}, 64'd0);
    chk({tag, "_idle_res"}, {24'd0, res_data_o}, {24'd0, ref_acc[39:0]});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, {63'd0, op_ready_o}, 64'd0);
    chk({tag, "_valid"}, {63'd0, res_valid_o}, 64'd0);
    chk({tag, "_res"}, {24'd0, res_data_o}, 64'd0);
    chk({tag, "_add1"}, {32'd0, add1_o}, 64'd0);
    chk({tag, "_add2"}, {32'd0, add2_o}, 64'd0);
    chk({tag, "_mm"}, {63'd0, mismatch_o}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
  endtask

  initial begin
    int rlen;
    checks      = 0;
    errors      = 0;
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    len_i       = 8'd0;
    op_valid_i  = 1'b0;
    op_data_i   = 32'hDEAD_BEEF;
    res_ready_i = 1'b0;
    fault_flip  = 1'b0;
    ref_acc     = 0;
    ref_mm      = 1'b0;
    #2;
    check_all_zero("reset");
    step();
    rst_ni = 1'b1;
    step();

    op_q = '{32'h1, 32'h2, 32'h3};
    run_burst("len3", 3, 0, 1'b0, 1'b0);
    chk("len3_const", {24'd0, res_data_o}, 64'h6);
    accept("len3", 0);

    op_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_burst("ones2", 2, 0, 1'b0, 1'b0);
    chk("ones2_const", {24'd0, res_data_o}, 64'h1_FFFF_FFFE);
    accept("ones2", 1);

    ref_acc = 0;
    ref_mm  = 1'b0;
    start_i = 1'b1;
    len_i   = 8'd0;
    step();
    start_i = 1'b0;
    chk("len0_valid", {63'd0, res_valid_o}, 64'd1);
    chk("len0_res", {24'd0, res_data_o}, 64'd0);
    chk("len0_busy", {63'd0, busy_o}, 64'd1);
    accept("len0", 5);

    op_q = '{32'h10, 32'h10, 32'h10, 32'h10};
    run_burst("fault", 4, 2, 1'b0, 1'b0);
    chk("fault_mm_const", {63'd0, mismatch_o}, 64'd1);
    accept("fault", 2);

    op_q = '{32'd5, 32'd7, 32'd9};
    run_burst("gap", 3, 0, 1'b1, 1'b1);
    chk("gap_const", {24'd0, res_data_o}, 64'd21);
    accept("gap", 0);

    op_q = {};
    for (int i = 0; i < 255; i++) op_q.push_back(32'hFFFF_FFFF);
    run_burst("max", 255, 0, 1'b0, 1'b0);
    chk("max_const", {24'd0, res_data_o}, 64'hFE_FFFF_FF01);
    accept("max", 0);

    for (int k = 0; k < 6; k++) begin
      rlen = $urandom_range(1, 8);
      op_q = {};
      for (int i = 0; i < rlen; i++) op_q.push_back($urandom);
      run_burst("rand", rlen, (k == 3) ? int'($urandom_range(1, rlen)) : 0, 1'b1, 1'b0);
      accept("rand", $urandom_range(0, 2));
    end

    start_i    = 1'b1;
    len_i      = 8'd4;
    step();
    start_i    = 1'b0;
    op_valid_i = 1'b1;
    op_data_i  = 32'h10;
    step();
    step();
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("rst_mid");
    #2;
    rst_ni     = 1'b1;
    op_valid_i = 1'b0;
    step();
    chk("rst_no_valid", {63'd0, res_valid_o}, 64'd0);

    op_q = '{32'hA};
    run_burst("post_rst", 1, 0, 1'b0, 1'b0);
    chk("post_rst_const", {24'd0, res_data_o}, 64'hA);
    accept("post_rst", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder32_accum_seq.md
Name: adder32_accum_seq

Overview:
- Sequencer that drives the 32-bit operand pair of the combinational 32-bit adder and consumes its 33-bit result.
- Sums a burst of len_i 32-bit operands into a wide accumulator.
- Cross-checks every adder result against an internal golden sum. Flags mismatches, such as a locked adder running with a wrong key.
- Sits between an operand stream source and the result consumer; the adder instance lives outside this block.

Parameters:
- DATA_W, 32, operand width; must match the adder.
- CNT_W, 8, burst-length counter width. The accumulator is DATA_W+CNT_W bits wide and cannot overflow.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  begin burst; sampled in IDLE only
- len_i  in  CNT_W  operand count; sampled with start_i
- op_valid_i  in  1  operand valid
- op_data_i  in  DATA_W  operand
- op_ready_o  out  1  operand accept
- add1_o  out  DATA_W  to adder add1_i
- add2_o  out  DATA_W  to adder add2_i
- sum_i  in  DATA_W+1  from adder result_o; combinational return, same cycle
- res_valid_o  out  1  result valid
- res_data_o  out  DATA_W+CNT_W  accumulated sum
- res_ready_i  in  1  result accept
- mismatch_o  out  1  sticky: adder result disagreed with golden sum
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: asynchronous, active-low. State=IDLE; acc, rem, mismatch cleared. All outputs 0: op_ready_o, res_valid_o, res_data_o, add1_o, add2_o, mismatch_o, busy_o.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - op_ready_o=0.
  - start_i with len_i!=0: acc<=0, rem<=len_i, mismatch<=0, go to ACCUM.
  - start_i with len_i==0: acc<=0, mismatch<=0, go to DONE.
- ACCUM:
  - op_ready_o=1.
  - add1_o = acc[DATA_W-1:0] (registered); add2_o = op_data_i (combinational).
  - Beat = op_valid_i & op_ready_o. On a beat:
    - acc[DATA_W-1:0] <= sum_i[DATA_W-1:0]
    - acc[top] <= acc[top] + sum_i[DATA_W]
    - rem <= rem-1
    - mismatch <= mismatch | (sum_i != golden), where golden = zero-extended add1_o + add2_o computed internally.
  - Beat with rem==1 -> DONE next cycle.
  - No beat: hold all state.
- DONE:
  - res_valid_o=1, res_data_o=acc; held stable until res_ready_i.
  - res_valid_o & res_ready_i -> IDLE.
  - res_data_o retains its last value in IDLE.
- Latency:
  - One operand per cycle with op_valid_i held.
  - Result valid the cycle after the last beat.
  - Back-to-back bursts possible: start_i may be asserted in the first IDLE cycle.
- start_i outside IDLE is ignored (no restart, no error).
- add1_o/add2_o outside ACCUM: add1_o = acc[DATA_W-1:0]; add2_o = 0.
- sum_i is not registered. Combinational path op_data_i -> add2_o -> adder -> sum_i -> acc is a single-cycle path by design.
- mismatch_o:
  - Sticky across the burst and through DONE.
  - Cleared only by an accepted start_i or reset.
  - Accumulation always uses sum_i, never golden, so faulty adder output is observable.
- Reset mid-burst: immediate return to IDLE. Partial result discarded; no res_valid_o pulse.
- Wrap: accumulator width guarantees no wrap for len_i <= 2^CNT_W-1 of all-ones operands.

Decomposition:
- Shared package adder32_pkg:
  - DATA_W and CNT_W defaults
  - state enum {IDLE, ACCUM, DONE}
  - ACC_W = DATA_W+CNT_W
- One natural sub-module: adder32_golden, a behavioural DATA_W-bit adder with DATA_W+1 output, used for the cross-check. It is reusable by other locked-adder wrappers.
- Top holds the FSM, counter and accumulator.

Test Plan:
- Burst len=3, ops 0x00000001, 0x00000002, 0x00000003, correct adder, valid every cycle -> res_data_o=0x6 one cycle after 3rd beat; mismatch_o=0.
- Burst len=2, ops 0xFFFFFFFF, 0xFFFFFFFF -> first beat carry=0; second sum_i=0x1FFFFFFFE -> res_data_o=0x1_FFFFFFFE; verify carry propagates into acc[39:32].
- len=0 start -> DONE next cycle, res_data_o=0. With res_ready_i low for 5 cycles, output held stable; with res_ready_i=1 -> IDLE, busy_o=0.
- Adder model forced to return sum_i xor 0x1 on beat 2 of len=4 ops all 0x10 -> mismatch_o=1 from cycle after beat 2 through DONE. Cleared on next accepted start_i.
- op_valid_i toggling 1,0,0,1,1 with len=3 ops 5,7,9 -> exactly 3 beats; res_data_o=21. start_i pulsed during ACCUM ignored.
- rst_ni low asynchronously mid-burst after 2 of 4 beats -> all outputs 0 immediately. After release, new len=1 op 0xA -> res_data_o=0xA.
